// File: rtl/vr_alu_arbiter.sv
// ============================================================================
// vr_alu_arbiter : round-robin sharing of one RV32I ALU between two ports,
//                  with a one-deep registered response slot per port.
// Optional statistics counters: define VR_ALU_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vr_alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [31:0]      i_req0_in1,
  input  logic [31:0]      i_req0_in2,
  input  logic [31:0]      i_req0_instr,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [31:0]      i_req1_in1,
  input  logic [31:0]      i_req1_in2,
  input  logic [31:0]      i_req1_instr,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [31:0]      o_rsp0_out,
  output logic [2:0]       o_rsp0_flags,
  output logic [31:0]      o_rsp0_add,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [31:0]      o_rsp1_out,
  output logic [2:0]       o_rsp1_flags,
  output logic [31:0]      o_rsp1_add,
  output logic [CNT_W-1:0] o_stat_grant0,
  output logic [CNT_W-1:0] o_stat_grant1,
  output logic [CNT_W-1:0] o_stat_conflict
);

  localparam logic S_EMPTY = 1'b0;
  localparam logic S_FULL  = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] out0_q, out1_q, add0_q, add1_q;
  logic [2:0]  flg0_q, flg1_q;

  logic        w_elig0, w_elig1, w_grant0, w_grant1;
  logic [31:0] w_in1, w_in2, w_instr, w_alu_out, w_add;
  logic [2:0]  w_flags;
  logic [4:0]  w_shamt;
  logic        w_unused;

  // A full slot is eligible only if it drains in the same cycle.
  assign w_elig0  = i_req0_valid & (!o_rsp0_valid | i_rsp0_ready);
  assign w_elig1  = i_req1_valid & (!o_rsp1_valid | i_rsp1_ready);
  assign w_grant0 = !i_rst & w_elig0 & (!w_elig1 |  last_grant_q);
  assign w_grant1 = !i_rst & w_elig1 & (!w_elig0 | !last_grant_q);

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;

  assign w_in1   = w_grant1 ? i_req1_in1   : i_req0_in1;
  assign w_in2   = w_grant1 ? i_req1_in2   : i_req0_in2;
  assign w_instr = w_grant1 ? i_req1_instr : i_req0_instr;

  // R-type shifts take the amount from in2, I-type from the shamt field.
  assign w_shamt = w_instr[5] ? w_in2[4:0] : w_instr[24:20];
  assign w_add   = w_in1 + w_in2;
  assign w_flags = {w_in1 == w_in2, $signed(w_in1) < $signed(w_in2), w_in1 < w_in2};
  assign w_unused = ^{w_instr[31], w_instr[29:25], w_instr[19:15], w_instr[11:6], w_instr[4:0]};

  always_comb begin
    w_alu_out = w_add;
    case (w_instr[14:12])
      3'd0: w_alu_out = (w_instr[5] & w_instr[30]) ? (w_in1 - w_in2) : w_add;
      3'd1: w_alu_out = w_in1 << w_shamt;
      3'd2: w_alu_out = {31'd0, w_flags[1]};
      3'd3: w_alu_out = {31'd0, w_flags[0]};
      3'd4: w_alu_out = w_in1 ^ w_in2;
      3'd5: w_alu_out = w_instr[30] ? 32'($signed(w_in1) >>> w_shamt) : (w_in1 >> w_shamt);
      3'd6: w_alu_out = w_in1 | w_in2;
      default: w_alu_out = w_in1 & w_in2;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= {S_EMPTY, S_EMPTY};
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (w_grant0) begin
      state_d[0]   = S_FULL;
      last_grant_d = 1'b0;
    end else if (i_rsp0_ready) begin
      state_d[0]   = S_EMPTY;
    end
    if (w_grant1) begin
      state_d[1]   = S_FULL;
      last_grant_d = 1'b1;
    end else if (i_rsp1_ready) begin
      state_d[1]   = S_EMPTY;
    end
  end

  always_comb begin
    o_rsp0_valid = (state_q[0] == S_FULL);
    o_rsp1_valid = (state_q[1] == S_FULL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out0_q <= '0; add0_q <= '0; flg0_q <= '0;
      out1_q <= '0; add1_q <= '0; flg1_q <= '0;
    end else begin
      if (w_grant0) begin
        out0_q <= w_alu_out; add0_q <= w_add; flg0_q <= w_flags;
      end
      if (w_grant1) begin
        out1_q <= w_alu_out; add1_q <= w_add; flg1_q <= w_flags;
      end
    end
  end

  assign o_rsp0_out   = out0_q;
  assign o_rsp0_add   = add0_q;
  assign o_rsp0_flags = flg0_q;
  assign o_rsp1_out   = out1_q;
  assign o_rsp1_add   = add1_q;
  assign o_rsp1_flags = flg1_q;

`ifdef VR_ALU_ARB_STATS_EN
  logic [CNT_W-1:0] g0_q, g1_q, conf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      g0_q   <= '0;
      g1_q   <= '0;
      conf_q <= '0;
    end else begin
      if (w_grant0 && g0_q != '1)              g0_q   <= g0_q + 1'b1;
      if (w_grant1 && g1_q != '1)              g1_q   <= g1_q + 1'b1;
      if (w_elig0 && w_elig1 && conf_q != '1)  conf_q <= conf_q + 1'b1;
    end
  end

  assign o_stat_grant0   = g0_q;
  assign o_stat_grant1   = g1_q;
  assign o_stat_conflict = conf_q;
`else
  assign o_stat_grant0   = '0;
  assign o_stat_grant1   = '0;
  assign o_stat_conflict = '0;
`endif

endmodule

`default_nettype wire

// File: doc/vr_alu_arbiter.md
Name: vr_alu_arbiter

Overview:
- Shares one combinational RV32I ALU instance between two requesters: port 0 (execute stage) and port 1 (address/branch helper).
- Each port has a valid/ready request channel carrying {in1, in2, instr}, and a one-deep registered response channel carrying {out, EQ, LT, LTU, add}.
- Round-robin arbitration; at most one ALU operation is issued per cycle; latency is 1 cycle from accept to response valid.

Parameters:
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- i_clk  in  1  system clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req0_valid / i_req1_valid  in  1  request valid, per port
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle (grant)
- i_req0_in1, i_req0_in2 / i_req1_in1, i_req1_in2  in  32  ALU operands
- i_req0_instr / i_req1_instr  in  32  instruction word (funct3/funct7/bit5/shamt decoded by the ALU)
- o_rsp0_valid / o_rsp1_valid  out  1  response slot full
- i_rsp0_ready / i_rsp1_ready  in  1  requester consumes the response
- o_rsp0_out / o_rsp1_out  out  32  registered ALU result
- o_rsp0_flags / o_rsp1_flags  out  3  registered {EQ, LT, LTU}
- o_rsp0_add / o_rsp1_add  out  32  registered in1+in2 (address adder)
- o_stat_grant0, o_stat_grant1, o_stat_conflict  out  CNT_W  statistics (see Optional Feature)

Behaviour:
- Eligibility: elig_k = i_reqk_valid & (!o_rspk_valid | i_rspk_ready). Port k's response slot must be empty, or draining this cycle.
- Grant rule:
  - Both ports eligible: grant the port != last_grant.
  - One port eligible: grant that port.
  - Neither eligible: no grant.
  - Never more than one grant per cycle.
- o_reqk_ready = grant_k. Ready depends combinationally on valid and i_rspk_ready; requesters must not make valid depend on ready.
- Requesters hold valid and payload stable until accepted. Dropping valid before accept is permitted and has no side effect.
- ALU mux: operands and instr are selected from the granted port (port 0 when there is no grant). The ALU output is unregistered inside the block.
- Accept on port k (valid & ready):
  - next cycle: o_rspk_valid=1; o_rspk_out/flags/add = ALU values from the accept cycle.
  - last_grant <= k.
- last_grant is unchanged in cycles with no grant.
- Drain: o_rspk_valid & i_rspk_ready with no new accept on k -> o_rspk_valid <= 0. Data registers hold their last value.
- Simultaneous drain and accept on the same port: slot reloads, valid stays 1, and the new data appears next cycle (full throughput, 1 op/cycle/port).
- Response registers change only on accept. With i_rspk_ready=0, valid and data are held indefinitely.
- The block performs no interpretation of opcodes: all ops (add/sub, shifts, slt/sltu, logic) complete in 1 cycle.
- Reset (i_rst=1 at a clock edge), including mid-operation:
  - o_rsp*_valid=0, response data=0, last_grant=1 (port 0 wins the first conflict), counters=0.
  - In-flight responses are discarded.
  - While i_rst=1, o_req*_ready=0.
- States (per port slot): EMPTY -> FULL on accept. FULL -> EMPTY on drain without accept. FULL -> FULL on drain+accept, or while stalled.

Optional Feature:
- Macro: VR_ALU_ARB_STATS_EN.
- Defined:
  - o_stat_grant0/1 increment on each accept of the respective port.
  - o_stat_conflict increments each cycle where both ports are eligible.
  - All counters saturate at 2^CNT_W-1 and are cleared by i_rst.
- Undefined: stat ports still exist, are driven constant 0, and no counter flops are inferred.

Test Plan:
- Port 0 only: instr=0x00000033 (add), in1=5, in2=7, i_rsp0_ready=1 -> ready0=1 in cycle t; cycle t+1 rsp0_valid=1, out=12, flags={0,1,1}, add=12.
- Port 1 only: instr=0x40000033 (sub), in1=3, in2=5 -> out=0xFFFFFFFE, flags={0,1,1}, add=8. Separately: instr=0x00401013 (slli 4), in1=1 -> out=16.
- Contention: both valid continuously, both rsp_ready=1, starting from reset -> grant sequence 0,1,0,1,...; each port gets one response every 2 cycles; o_stat_conflict increments every cycle (STATS_EN).
- Backpressure: rsp0 full, i_rsp0_ready=0, both valid -> ready0=0 held, port 1 granted every cycle, rsp0 data unchanged. Raise i_rsp0_ready -> port 0 granted within 1 cycle (it is != last_grant).
- Reset mid-operation: accept on port 0, assert i_rst the next cycle -> rsp0_valid=0, outputs 0, counters 0; first conflict after reset is granted to port 0.
- Saturation (CNT_W=4, STATS_EN): 20 back-to-back port-0 accepts -> o_stat_grant0=15 and stays there. Without the macro, all stat outputs = 0.
